// File: rtl/edge_lag_pkg.sv
// edge_lag_pkg: shared types and defaults for the edge_lag_meter block.
//   lag_entry_t : one FIFO result {tmo, rise, lag} at the default counter width
//   state_t     : measurement FSM states
//   DEF_CNT_W   : default lag counter width
//   DEF_DEPTH   : default result FIFO depth
package edge_lag_pkg;

  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                 tmo;
    logic                 rise;
    logic [DEF_CNT_W-1:0] lag;
  } lag_entry_t;

endpackage

// File: rtl/edge_lag_sync.sv
// edge_lag_sync: input stage for one sampled net.
//   EDGE_LAG_SYNC_EN defined   : 2-flop synchronizer, for asynchronous nets.
//   EDGE_LAG_SYNC_EN undefined : single sampling flop, for nets already
//                                synchronous to clk.
// Ports:
//   clk   in  sampling clock
//   rst_n in  synchronous active-low reset (all flops clear to 0)
//   d     in  raw net
//   q     out sampled net
module edge_lag_sync
  import edge_lag_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

`ifdef EDGE_LAG_SYNC_EN
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end
`endif

endmodule

// File: rtl/edge_lag_meter.sv
// edge_lag_meter: measures, in clk cycles, how long each transition on sig_in
// takes to show up on sig_out, and queues one result per transition in a
// show-ahead FIFO.
// Build option: EDGE_LAG_SYNC_EN selects a 2-flop synchronizer per net
// (detect latency 2 cycles) instead of a single sampling flop (1 cycle).
// Lag values are identical in both builds.
// Parameters:
//   CNT_W  lag counter width, MAX_LAG = 2**CNT_W-1
//   DEPTH  FIFO entries, power of two, >= 2
// Ports:
//   clk       in  sampling clock
//   rst_n     in  synchronous active-low reset
//   sig_in    in  upstream net of the measured stage
//   sig_out   in  downstream net of the measured stage
//   rd_en     in  pop FIFO head (ignored when empty)
//   lag_valid out FIFO not empty
//   lag_data  out head lag in cycles (0 when empty)
//   lag_rise  out head measured a rising transition (0 when empty)
//   lag_tmo   out head is a timeout or abandoned measurement (0 when empty)
//   fifo_full out DEPTH entries held
//   ovf       out sticky: a result was dropped
//   busy      out measurement in progress
module edge_lag_meter
  import edge_lag_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             sig_out,
  input  logic             rd_en,
  output logic             lag_valid,
  output logic [CNT_W-1:0] lag_data,
  output logic             lag_rise,
  output logic             lag_tmo,
  output logic             fifo_full,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX_LAG = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Same layout as lag_entry_t, but sized by this instance's CNT_W.
  typedef struct packed {
    logic             tmo;
    logic             rise;
    logic [CNT_W-1:0] lag;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Sampling and edge detect
  // ---------------------------------------------------------------------------
  logic s_in, s_out;
  logic prev_in, prev_out;
  logic in_edge, out_edge;

  edge_lag_sync u_sync_in (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .q     (s_in)
  );

  edge_lag_sync u_sync_out (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_out),
    .q     (s_out)
  );

  // prev flops clear to 0, so a net already high at reset release is seen
  // as a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_in  <= 1'b0;
      prev_out <= 1'b0;
    end else begin
      prev_in  <= s_in;
      prev_out <= s_out;
    end
  end

  assign in_edge  = s_in  != prev_in;
  assign out_edge = s_out != prev_out;

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  logic             exp_pol;
  logic [CNT_W-1:0] cnt;
  logic             out_match;
  logic             push;
  entry_t           push_entry;

  assign out_match = out_edge && (s_out == exp_pol);

  // At most one result per cycle; a matching out-edge wins over a new
  // in-edge, which wins over the timeout.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    case (state)
      IDLE: begin
        if (in_edge && out_edge && (s_in == s_out)) begin
          push            = 1'b1;
          push_entry.rise = s_in;
        end
      end
      WAIT: begin
        if (out_match) begin
          push            = 1'b1;
          push_entry.rise = exp_pol;
          push_entry.lag  = cnt;
        end else if (in_edge) begin
          push            = 1'b1;
          push_entry.tmo  = 1'b1;
          push_entry.rise = exp_pol;
          push_entry.lag  = cnt;
        end else if (cnt == MAX_LAG) begin
          push            = 1'b1;
          push_entry.tmo  = 1'b1;
          push_entry.rise = exp_pol;
          push_entry.lag  = MAX_LAG;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      exp_pol <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_edge && !(out_edge && (s_in == s_out))) begin
            state   <= WAIT;
            exp_pol <= s_in;
            cnt     <= CNT_ONE;
          end
        end
        WAIT: begin
          if (out_match) begin
            if (in_edge) begin
              exp_pol <= s_in;
              cnt     <= CNT_ONE;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else if (in_edge) begin
            exp_pol <= s_in;
            cnt     <= CNT_ONE;
          end else if (cnt == MAX_LAG) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == WAIT);

  // ---------------------------------------------------------------------------
  // Result FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full;
  logic          pop, wr;
  entry_t        head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rd_en && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (wr) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign lag_valid = !empty;
  assign lag_data  = empty ? '0 : head.lag;
  assign lag_rise  = empty ? 1'b0 : head.rise;
  assign lag_tmo   = empty ? 1'b0 : head.tmo;
  assign fifo_full = full;

endmodule

// File: tb/tb_edge_lag_meter.sv
// tb_edge_lag_meter: table-driven directed measurements, hand-written corner
// sequences, and a randomized phase checked against a timestamp-based model.
module tb_edge_lag_meter;

  localparam int CNT_W   = 4;
  localparam int DEPTH   = 4;
  localparam int MAX_LAG = 15;
`ifdef EDGE_LAG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             sig_out = 1'b0;
  logic             rd_en = 1'b0;
  logic             lag_valid;
  logic [CNT_W-1:0] lag_data;
  logic             lag_rise;
  logic             lag_tmo;
  logic             fifo_full;
  logic             ovf;
  logic             busy;

  always #5 clk = ~clk;

  edge_lag_meter #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .rd_en     (rd_en),
    .lag_valid (lag_valid),
    .lag_data  (lag_data),
    .lag_rise  (lag_rise),
    .lag_tmo   (lag_tmo),
    .fifo_full (fifo_full),
    .ovf       (ovf),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an open measurement is a start timestamp plus expected
  // polarity; lag is the cycle distance. Results go into a bounded queue.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit tmo;
    bit rise;
    int lag;
  } ent_t;

  ent_t m_q[$];
  bit   m_pend = 0, m_pol = 0, m_ovf = 0;
  int   m_start = 0, m_cyc = 0;
  bit   m_pin[LAT];
  bit   m_pout[LAT];
  bit   m_prev_in = 0, m_prev_out = 0;

  task automatic model_step();
    bit   si, so, ie, oe, pop, push, full;
    ent_t e;
    int   lag;
    if (!rst_n) begin
      m_q.delete();
      m_pend = 0; m_pol = 0; m_ovf = 0;
      for (int j = 0; j < LAT; j++) begin m_pin[j] = 0; m_pout[j] = 0; end
      m_prev_in = 0; m_prev_out = 0;
      m_cyc++;
      return;
    end
    si = m_pin[LAT-1];
    so = m_pout[LAT-1];
    ie = si != m_prev_in;
    oe = so != m_prev_out;
    push = 0;
    e = '{0, 0, 0};
    lag = m_cyc - m_start;
    if (!m_pend) begin
      if (ie && oe && si == so) begin
        push = 1; e = '{0, si, 0};
      end else if (ie) begin
        m_pend = 1; m_start = m_cyc; m_pol = si;
      end
    end else if (oe && so == m_pol) begin
      push = 1; e = '{0, m_pol, lag};
      if (ie) begin m_start = m_cyc; m_pol = si; end
      else m_pend = 0;
    end else if (ie) begin
      push = 1; e = '{1, m_pol, lag};
      m_start = m_cyc; m_pol = si;
    end else if (lag == MAX_LAG) begin
      push = 1; e = '{1, m_pol, MAX_LAG};
      m_pend = 0;
    end
    full = m_q.size() == DEPTH;
    pop  = rd_en && m_q.size() != 0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else m_q.push_back(e);
    end
    m_prev_in  = si;
    m_prev_out = so;
    for (int j = LAT-1; j > 0; j--) begin
      m_pin[j]  = m_pin[j-1];
      m_pout[j] = m_pout[j-1];
    end
    m_pin[0]  = sig_in;
    m_pout[0] = sig_out;
    m_cyc++;
  endtask

  initial begin
    for (int j = 0; j < LAT; j++) begin m_pin[j] = 0; m_pout[j] = 0; end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  bit rand_on = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rand_on) begin
        chk("rnd_valid", lag_valid, int'(m_q.size() != 0));
        chk("rnd_lag",  lag_data, (m_q.size() != 0) ? m_q[0].lag : 0);
        chk("rnd_rise", lag_rise, (m_q.size() != 0) ? int'(m_q[0].rise) : 0);
        chk("rnd_tmo",  lag_tmo,  (m_q.size() != 0) ? int'(m_q[0].tmo) : 0);
        chk("rnd_full", fifo_full, int'(m_q.size() == DEPTH));
        chk("rnd_ovf",  ovf, int'(m_ovf));
        chk("rnd_busy", busy, int'(m_pend));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  // Drive sig_in to lvl, then sig_out to lvl d cycles later (d<0: never),
  // and count cycles with busy high over a fixed window.
  task automatic measure(input bit lvl, input int d, output int busy_n);
    busy_n = 0;
    @(posedge clk); #1;
    sig_in = lvl;
    if (d == 0) sig_out = lvl;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (c == d) sig_out = lvl;
      @(negedge clk);
      busy_n += int'(busy);
    end
  endtask

  task automatic pop_one();
    @(posedge clk); #1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_head(input string tag, input int lag, input bit rise, input bit tmo);
    chk({tag, "_valid"}, lag_valid, 1);
    chk({tag, "_lag"}, lag_data, lag);
    chk({tag, "_rise"}, lag_rise, int'(rise));
    chk({tag, "_tmo"}, lag_tmo, int'(tmo));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, lag_valid, 0);
    chk({tag, "_lag"}, lag_data, 0);
    chk({tag, "_rise"}, lag_rise, 0);
    chk({tag, "_tmo"}, lag_tmo, 0);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    bit lvl;
    int d;
    int lag;
    bit rise;
    bit tmo;
    int busy_n;
  } row_t;

  row_t rows[8];

  initial begin
    int b;
    rows = '{
      '{1,  3,  3, 1, 0,  3},   // rising, follows 3 cycles later
      '{0,  0,  0, 0, 0,  0},   // falling, same period: lag 0, never busy
      '{1,  5,  5, 1, 0,  5},
      '{0,  1,  1, 0, 0,  1},
      '{1, -1, 15, 1, 1, 15},   // sig_out held: timeout at MAX_LAG
      '{0,  2, 15, 0, 1, 15},   // sig_out already low: no out-edge, timeout
      '{1, 14, 14, 1, 0, 14},   // one below MAX_LAG
      '{0, 15, 15, 0, 0, 15}    // match on the MAX_LAG cycle beats timeout
    };

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      measure(rows[i].lvl, rows[i].d, b);
      chk({tag, "_busy_cycles"}, b, rows[i].busy_n);
      check_head(tag, rows[i].lag, rows[i].rise, rows[i].tmo);
      pop_one();
      chk({tag, "_empty_after_pop"}, lag_valid, 0);
    end

    // Out-edge while idle is ignored.
    @(posedge clk); #1 sig_out = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("idle_out_valid", lag_valid, 0);
    chk("idle_out_busy", busy, 0);

    // Two in-edges 2 cycles apart, sig_out follows the second 4 cycles later.
    @(posedge clk); #1 sig_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 sig_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 sig_out = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_head("abandon_1st", 2, 1, 1);
    pop_one();
    check_head("abandon_2nd", 4, 0, 0);
    pop_one();
    chk("abandon_empty", lag_valid, 0);

    // Five results without reads: full after four, fifth dropped.
    for (int i = 0; i < 5; i++) begin
      measure(bit'(i % 2 == 0), i + 1, b);
      if (i == 3) begin
        chk("ovf_full_at4", fifo_full, 1);
        chk("ovf_clear_at4", ovf, 0);
      end
    end
    chk("ovf_full_at5", fifo_full, 1);
    chk("ovf_set_at5", ovf, 1);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("ovf_rd%0d", i), i + 1, bit'(i % 2 == 0), 0);
      pop_one();
    end
    chk("ovf_drained", lag_valid, 0);
    chk("ovf_not_full", fifo_full, 0);
    chk("ovf_sticky", ovf, 1);

    // Reset mid-measurement, then a fresh measurement starts at lag 1.
    @(posedge clk); #1 sig_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    rst_n   = 1'b0;
    sig_out = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("rstmid");
    measure(1'b1, 1, b);
    check_head("after_rst", 1, 1, 0);
    chk("after_rst_busy_cycles", b, 1);
    pop_one();

    // Randomized phase against the model.
    rand_on = 1;
    for (int c = 0; c < 3000; c++) begin
      int p;
      int r;
      @(posedge clk); #1;
      p = (c < 1500) ? 6 : 40;
      if ($urandom_range(p - 1) == 0) sig_in = ~sig_in;
      r = int'($urandom_range(15));
      if (r < 3) sig_out = sig_in;
      else if (r == 3) sig_out = ~sig_out;
      rd_en = ($urandom_range(2) == 0);
      rst_n = ($urandom_range(499) != 0);
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rand_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
